// File: rtl/fifo_ser_pkg.sv
// Shared types and elaboration helpers for the FIFO drain serializer.
// Contents:
//   ser_state_t    - serializer FSM state (IDLE, SHIFT)
//   ser_ratio      - number of beats per FIFO word
//   ser_cnt_width  - width of the beat counter (at least 1 bit)
//   ser_params_ok  - legality check on the width parameters
package fifo_ser_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  function automatic int unsigned ser_ratio(input int unsigned iw, input int unsigned ow);
    return iw / ow;
  endfunction

  function automatic int unsigned ser_cnt_width(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic bit ser_params_ok(input int unsigned iw, input int unsigned ow);
    return (ow != 0) && (iw % ow == 0) && (iw / ow >= 2);
  endfunction

endpackage

// File: rtl/fifo_drain_serializer.sv
// Drain stage between a FIFO read port and a narrow valid/ready sink. Pops one in_width-bit
// word when the FIFO is not empty and the stage is free (or about to finish its last beat),
// then emits it as in_width/out_width beats, flagging the final beat and counting words sent.
//
// Build option: define FIFO_SER_MSB_FIRST_EN to emit beats MSB-first (default LSB-first).
//
// Ports:
//   clk         clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   empty       FIFO empty flag
//   read_data   FIFO head word, valid while empty == 0
//   pop         FIFO pop strobe (combinational)
//   out_valid   beat valid (registered)
//   out_ready   sink ready
//   out_data    current beat (registered)
//   out_last    current beat is the last of its word
//   word_count  fully sent words, wraps
module fifo_drain_serializer
  import fifo_ser_pkg::*;
#(
  parameter int unsigned in_width  = 8,
  parameter int unsigned out_width = 2,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 empty,
  input  logic [in_width-1:0]  read_data,
  output logic                 pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [out_width-1:0] out_data,
  output logic                 out_last,
  output logic [cnt_width-1:0] word_count
);

  localparam int unsigned Ratio = ser_ratio(in_width, out_width);
  localparam int unsigned CntW  = ser_cnt_width(Ratio);
  localparam logic [CntW-1:0] LastBeat = CntW'(Ratio - 1);

  if (!ser_params_ok(in_width, out_width)) begin : g_bad_params
    $error("fifo_drain_serializer: in_width must be a multiple of out_width with ratio >= 2");
  end

  ser_state_t           state_q, state_d;
  logic [in_width-1:0]  shift_q, shift_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [cnt_width-1:0] count_q, count_d;

  logic                 acc;
  logic                 last;
  logic                 take;
  logic [in_width-1:0]  shifted;

  assign acc  = valid_q & out_ready;
  assign last = (state_q == SHIFT) && (cnt_q == LastBeat);
  assign take = !empty & ((state_q == IDLE) | ((state_q == SHIFT) & acc & last));

`ifdef FIFO_SER_MSB_FIRST_EN
  assign out_data = shift_q[in_width-1 -: out_width];
  assign shifted  = shift_q << out_width;
`else
  assign out_data = shift_q[out_width-1:0];
  assign shifted  = shift_q >> out_width;
`endif

  // The FIFO does not guard pop, so keep it low while held in reset.
  assign pop        = take & rst_n;
  assign out_valid  = valid_q;
  assign out_last   = last;
  assign word_count = count_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          shift_d = read_data;
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (acc) begin
          if (!last) begin
            shift_d = shifted;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            count_d = count_q + 1'b1;
            cnt_d   = '0;
            if (take) begin
              // Reload straight from the FIFO head so words run back to back.
              shift_d = read_data;
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Self-checking bench for fifo_drain_serializer (in_width=8, out_width=2). A small FIFO model
// with a registered empty flag feeds the DUT; expected beats go into a scoreboard queue and a
// monitor compares every accepted beat.
module tb_fifo_drain_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        empty = 1'b1;
  logic [7:0]  read_data = 8'h00;
  logic        pop;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_data;
  logic        out_last;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] data;
    logic       last;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] fq[$];
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  int         pop_cnt = 0;

  always #5 clk = ~clk;

  fifo_drain_serializer #(
    .in_width (8),
    .out_width(2),
    .cnt_width(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .empty     (empty),
    .read_data (read_data),
    .pop       (pop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .word_count(word_count)
  );

  // FIFO model: empty and head word are registered, like a real FIFO read side.
  always @(posedge clk) begin
    if (pop && fq.size() > 0) begin
      void'(fq.pop_front());
      pop_cnt++;
    end
    if (push) fq.push_back(push_data);
    empty     <= (fq.size() == 0);
    read_data <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed beat sequences, beat 0 in bits [7:6].
  function automatic logic [7:0] beats_of(input logic [7:0] w);
`ifdef FIFO_SER_MSB_FIRST_EN
    case (w)
      8'hB4:   return 8'b10_11_01_00;
      8'h12:   return 8'b00_01_00_10;
      8'h34:   return 8'b00_11_01_00;
      default: return 8'h00;
    endcase
`else
    case (w)
      8'hB4:   return 8'b00_01_11_10;
      8'h12:   return 8'b10_00_01_00;
      8'h34:   return 8'b00_01_11_00;
      default: return 8'h00;
    endcase
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] w);
    logic [7:0] b;
    b = beats_of(w);
    for (int k = 0; k < 4; k++) begin
      beat_t e;
      e.data = b[7-2*k -: 2];
      e.last = (k == 3);
      sb.push_back(e);
    end
    push      = 1'b1;
    push_data = w;
    tick();
    push = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid got 0 expected 1 within 50 cycles", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check({name, "_drained"}, sb.size(), 0);
  endtask

  // Monitor: compare each accepted beat against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %0h last %0b expected no beat", out_data,
                   out_last);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL beat: got data %0h last %0b expected data %0h last %0b at %0t",
                     out_data, out_last, e.data, e.last, $time);
          end
        end
      end
      if (pop && empty) begin
        checks++;
        errors++;
        $display("FAIL pop_while_empty: got pop 1 expected 0 at %0t", $time);
      end
    end
  end

  initial begin
    int p0;
    // 1: reset with a non-empty FIFO
    tick();
    push_word(8'hB4);
    tick();
    tick();
    check("rst_pop", pop, 0);
    check("rst_valid", out_valid, 0);
    check("rst_count", word_count, 0);
    check("rst_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    check("rel_pop", pop, 1);
    tick();
    check("beat0_valid", out_valid, 1);
    wait_drain("single");
    check("single_pops", pop_cnt, 1);
    check("single_count", word_count, 1);

    // 3: backpressure holding beat 1
    push_word(8'hB4);
    wait_valid("bp");
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data", out_data, 2'b01);
      check("bp_valid", out_valid, 1);
      check("bp_pop", pop, 0);
    end
    out_ready = 1'b1;
    wait_drain("bp");
    check("bp_count", word_count, 2);

    // 4: back-to-back words without a bubble
    p0 = pop_cnt;
    push_word(8'h12);
    push_word(8'h34);
    wait_valid("b2b");
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", out_valid, 1);
      if (i == 3) check("b2b_pop", pop, 1);
      tick();
    end
    wait_drain("b2b");
    check("b2b_pops", pop_cnt - p0, 2);
    check("b2b_count", word_count, 4);

    // 5: idle with empty FIFO, then a single push
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pop !== 1'b0 || out_valid !== 1'b0) check("idle_quiet", {pop, out_valid}, 0);
    end
    check("idle_pop", pop, 0);
    check("idle_valid", out_valid, 0);
    push_word(8'hB4);
    check("lat_pop", pop, 1);
    check("lat_valid0", out_valid, 0);
    tick();
    check("lat_valid1", out_valid, 1);
    wait_drain("lat");
    check("lat_count", word_count, 5);

    // 6: reset after two beats of a word
    push_word(8'hB4);
    wait_valid("midrst");
    tick();
    tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_count", word_count, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) check("midrst_quiet", out_valid, 0);
    end
    check("midrst_after", out_valid, 0);
    check("midrst_count2", word_count, 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
